// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a binary producer and the bin2bcd_seq converter.
// The slave modport is the converter side. The master modport is the producer/display side.
interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] bin_in;
  logic             bin_vld;
  logic             bin_rdy;
  logic [15:0]      bcd_out;
  logic             bcd_vld;
  logic             ovf;

  modport master (
    output bin_in, bin_vld,
    input  bin_rdy, bcd_out, bcd_vld, ovf
  );

  modport slave (
    input  bin_in, bin_vld,
    output bin_rdy, bcd_out, bcd_vld, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, feeding the tube driver.
// Optional macro BIN2BCD_SAT_EN: overflow shows 9999 (saturate) instead of EEEE.
module bin2bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic           clk,
  input  logic           rst_n,
  bin2bcd_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam int CNT_W = $clog2(BIN_W + 1);
`ifdef BIN2BCD_SAT_EN
  localparam logic [15:0] OVF_WORD = 16'h9999;
`else
  localparam logic [15:0] OVF_WORD = 16'hEEEE;
`endif

  state_t           state_q,   state_d;
  logic [BIN_W-1:0] shift_q,   shift_d;
  logic [15:0]      bcd_q,     bcd_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             ovf_int_q, ovf_int_d;
  logic [15:0]      bcd_out_q, bcd_out_d;
  logic             ovf_q,     ovf_d;
  logic             bcd_vld_q, bcd_vld_d;

  logic [15:0]      bcd_adj;
  logic             bin_over;

  // Add-3 correction on every nibble before the shift.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                            : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign bin_over = 32'(bus.bin_in) > 32'(MAX_VAL);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_int_d = ovf_int_q;
    bcd_out_d = bcd_out_q;
    ovf_d     = ovf_q;
    bcd_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bin_vld) begin
          shift_d   = bus.bin_in;
          bcd_d     = '0;
          cnt_d     = CNT_W'(BIN_W);
          ovf_int_d = bin_over;
          state_d   = CONV;
        end
      end
      CONV: begin
        // Top scratch bit is dropped; only reachable on overflow, whose result is replaced.
        bcd_d   = {bcd_adj[14:0], shift_q[BIN_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_out_d = ovf_int_q ? OVF_WORD : bcd_q;
        ovf_d     = ovf_int_q;
        bcd_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      bcd_out_q <= '0;
      ovf_q     <= 1'b0;
      bcd_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_int_q <= ovf_int_d;
      bcd_out_q <= bcd_out_d;
      ovf_q     <= ovf_d;
      bcd_vld_q <= bcd_vld_d;
    end
  end

  assign bus.bin_rdy = (state_q == IDLE);
  assign bus.bcd_out = bcd_out_q;
  assign bus.bcd_vld = bcd_vld_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: reset, conversions, boundaries, overflow,
// back-to-back handshake and mid-conversion reset.
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;
`ifdef BIN2BCD_SAT_EN
  localparam logic [15:0] OVF_EXP = 16'h9999;
`else
  localparam logic [15:0] OVF_EXP = 16'hEEEE;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(BIN_W)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until bcd_vld is seen; k returns the number of edges since the accept edge.
  task automatic wait_vld(output int k);
    k = 0;
    do begin
      tick();
      k++;
      if (k == BIN_W) check("rdy_low_in_done", 16'(bus.bin_rdy), 16'h0);
    end while (bus.bcd_vld !== 1'b1 && k < 40);
  endtask

  task automatic convert(input logic [13:0] val, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input string tag);
    int k;
    k = 0;
    while (bus.bin_rdy !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check({tag, " rdy_before"}, 16'(bus.bin_rdy), 16'h1);
    bus.bin_in  = val;
    bus.bin_vld = 1'b1;
    tick();
    bus.bin_vld = 1'b0;
    bus.bin_in  = ~val;
    check({tag, " rdy_after_accept"}, 16'(bus.bin_rdy), 16'h0);
    wait_vld(k);
    check({tag, " latency"}, 16'(k), 16'(BIN_W + 1));
    check({tag, " bcd_out"}, bus.bcd_out, exp_bcd);
    check({tag, " ovf"}, 16'(bus.ovf), 16'(exp_ovf));
    check({tag, " rdy_next"}, 16'(bus.bin_rdy), 16'h1);
    $display("[TB] convert %0d -> bcd %h ovf %0b after %0d cycles", val, bus.bcd_out, bus.ovf, k);
    tick();
    check({tag, " vld_one_cycle"}, 16'(bus.bcd_vld), 16'h0);
  endtask

  initial begin
    int k;
    int pulses;
    bus.bin_in  = '0;
    bus.bin_vld = 1'b0;

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst bcd_out", bus.bcd_out, 16'h0000);
    check("rst ovf", 16'(bus.ovf), 16'h0);
    check("rst bcd_vld", 16'(bus.bcd_vld), 16'h0);
    check("rst bin_rdy", 16'(bus.bin_rdy), 16'h1);

    convert(14'd1234, 16'h1234, 1'b0, "basic_1234");

    // Asynchronous clear between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async bcd_out", bus.bcd_out, 16'h0000);
    check("async bin_rdy", 16'(bus.bin_rdy), 16'h1);
    #2;
    rst_n = 1'b1;
    tick();

    convert(14'd0,    16'h0000, 1'b0, "zero");
    convert(14'd9999, 16'h9999, 1'b0, "max_val");
    convert(14'd7,    16'h0007, 1'b0, "seven");
    convert(14'd10000, OVF_EXP, 1'b1, "ovf_10000");
    convert(14'd16383, OVF_EXP, 1'b1, "ovf_16383");
    convert(14'd42,   16'h0042, 1'b0, "after_ovf_42");

    // Back-to-back with bin_vld held high
    bus.bin_in  = 14'd4321;
    bus.bin_vld = 1'b1;
    tick();
    check("b2b first accept", 16'(bus.bin_rdy), 16'h0);
    bus.bin_in = 14'd815;
    wait_vld(k);
    check("b2b first latency", 16'(k), 16'(BIN_W + 1));
    check("b2b first bcd_out", bus.bcd_out, 16'h4321);
    check("b2b rdy before second", 16'(bus.bin_rdy), 16'h1);
    $display("[TB] b2b convert 4321 -> bcd %h ovf %0b", bus.bcd_out, bus.ovf);
    tick();
    check("b2b second accept at +16", 16'(bus.bin_rdy), 16'h0);
    bus.bin_in  = 14'd9999;
    bus.bin_vld = 1'b0;
    wait_vld(k);
    check("b2b second latency", 16'(k), 16'(BIN_W + 1));
    check("b2b second bcd_out", bus.bcd_out, 16'h0815);
    check("b2b second ovf", 16'(bus.ovf), 16'h0);
    $display("[TB] b2b convert 815 -> bcd %h ovf %0b", bus.bcd_out, bus.ovf);
    tick();

    // Reset in the middle of a conversion
    bus.bin_in  = 14'd5678;
    bus.bin_vld = 1'b1;
    tick();
    bus.bin_vld = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midrst bcd_out", bus.bcd_out, 16'h0000);
    check("midrst bin_rdy", 16'(bus.bin_rdy), 16'h1);
    check("midrst bcd_vld", 16'(bus.bcd_vld), 16'h0);
    pulses = 0;
    repeat (3) begin
      tick();
      if (bus.bcd_vld === 1'b1) pulses++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      if (bus.bcd_vld === 1'b1) pulses++;
    end
    check("midrst no pulse", 16'(pulses), 16'h0);
    check("midrst bcd_out held", bus.bcd_out, 16'h0000);
    $display("[TB] aborted convert 5678 -> bcd %h, %0d pulses", bus.bcd_out, pulses);

    convert(14'd11, 16'h0011, 1'b0, "after_rst_11");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
